// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, byte-lane selects.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Big-endian lanes: bit 3 enables data[31:24] (byte offset 0)
  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_B0   = 4'b1000;
  localparam logic [3:0] SEL_B1   = 4'b0100;
  localparam logic [3:0] SEL_B2   = 4'b0010;
  localparam logic [3:0] SEL_B3   = 4'b0001;
  localparam logic [3:0] SEL_H0   = 4'b1100;
  localparam logic [3:0] SEL_H1   = 4'b0011;
  localparam logic [3:0] SEL_W    = 4'b1111;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational big-endian lane steering: store replication/byte enables,
// load lane extraction with sign/zero extension, and alignment/size error.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        off_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [3:0]        sel_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    sel_o   = SEL_NONE;
    wdata_o = '0;
    rdata_o = '0;
    err_o   = 1'b0;
    byte_v  = 8'h00;
    half_v  = 16'h0000;
    case (size_i)
      SZ_BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        case (off_i)
          2'd0:    begin sel_o = SEL_B0; byte_v = rdata_i[31:24]; end
          2'd1:    begin sel_o = SEL_B1; byte_v = rdata_i[23:16]; end
          2'd2:    begin sel_o = SEL_B2; byte_v = rdata_i[15:8];  end
          default: begin sel_o = SEL_B3; byte_v = rdata_i[7:0];   end
        endcase
        rdata_o = signed_i ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
      end
      SZ_HALF: begin
        wdata_o = {2{wdata_i[15:0]}};
        err_o   = off_i[0];
        if (off_i[1]) begin
          sel_o  = SEL_H1;
          half_v = rdata_i[15:0];
        end else begin
          sel_o  = SEL_H0;
          half_v = rdata_i[31:16];
        end
        rdata_o = signed_i ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
      end
      SZ_WORD: begin
        sel_o   = SEL_W;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        err_o   = |off_i;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and a byte-laned word RAM.
// One request at a time: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              stall_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_sel_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d, signed_q, signed_d;
  logic [1:0]        size_q, size_d, off_q, off_d;
  logic              ready_q, ready_d, valid_q, valid_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, mdata_q, mdata_d;
  logic              ce_q, ce_d, mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [3:0]        sel_q, sel_d;

  logic              idle_c;
  logic [1:0]        al_size_c, al_off_c;
  logic              al_signed_c, al_err_c;
  logic [3:0]        al_sel_c;
  logic [DATA_W-1:0] al_wdata_c, al_rdata_c;

  // Aligner sees the incoming request in IDLE, the captured request otherwise
  assign idle_c      = (state_q == ST_IDLE);
  assign al_size_c   = idle_c ? req_size_i       : size_q;
  assign al_off_c    = idle_c ? req_addr_i[1:0]  : off_q;
  assign al_signed_c = idle_c ? req_signed_i     : signed_q;

  lsu_lane_align u_align (
    .size_i   (al_size_c),
    .off_i    (al_off_c),
    .signed_i (al_signed_c),
    .wdata_i  (req_wdata_i),
    .rdata_i  (mem_data_i),
    .sel_o    (al_sel_c),
    .wdata_o  (al_wdata_c),
    .rdata_o  (al_rdata_c),
    .err_o    (al_err_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    off_d    = off_q;
    ready_d  = 1'b0;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    ce_d     = 1'b0;
    mwe_d    = 1'b0;
    maddr_d  = '0;
    sel_d    = SEL_NONE;
    mdata_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          size_d   = req_size_i;
          signed_d = req_signed_i;
          off_d    = req_addr_i[1:0];
          if (al_err_c) begin
            state_d = ST_RESP;
            valid_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = WAIT_INIT;
            ce_d    = 1'b1;
            mwe_d   = req_we_i && (WAIT_INIT == '0);
            maddr_d = {req_addr_i[ADDR_W-1:2], 2'b00};
            sel_d   = al_sel_c;
            mdata_d = al_wdata_c;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          rdata_d = we_q ? '0 : al_rdata_c;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          ce_d    = 1'b1;
          mwe_d   = we_q && (cnt_q == CNT_W'(1));
          maddr_d = maddr_q;
          sel_d   = sel_q;
          mdata_d = mdata_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      off_q    <= 2'b00;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      ce_q     <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      sel_q    <= SEL_NONE;
      mdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      off_q    <= off_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      ce_q     <= ce_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      sel_q    <= sel_d;
      mdata_q  <= mdata_d;
    end
  end

  // Stall drops in RESP so the pipeline advances with the response
  assign stall_o      = (state_q == ST_ACCESS) | (idle_c & req_valid_i);
  assign req_ready_o  = ready_q;
  assign resp_valid_o = valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_ce_o     = ce_q;
  assign mem_we_o     = mwe_q;
  assign mem_addr_o   = maddr_q;
  assign mem_sel_o    = sel_q;
  assign mem_data_o   = mdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a WAIT_CYCLES=0 and a WAIT_CYCLES=3 instance,
// each with its own byte-laned RAM model.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic clk;
  logic ram_clr;
  logic [1:0] rst, req_valid, req_ready, req_we, req_signed;
  logic [1:0] resp_valid, resp_err, stall, ce, mwe;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr, req_wdata, resp_rdata, maddr, mdata_o, mdata_i;
  logic [1:0][3:0]  msel;
  logic [31:0] ram [2][16];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_we_i(req_we[0]), .req_size_i(req_size[0]), .req_signed_i(req_signed[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .resp_valid_o(resp_valid[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]), .stall_o(stall[0]),
    .mem_ce_o(ce[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]), .mem_sel_o(msel[0]),
    .mem_data_o(mdata_o[0]), .mem_data_i(mdata_i[0])
  );

  lsu_mem_ctrl #(.ADDR_W(32), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_we_i(req_we[1]), .req_size_i(req_size[1]), .req_signed_i(req_signed[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .resp_valid_o(resp_valid[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]), .stall_o(stall[1]),
    .mem_ce_o(ce[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]), .mem_sel_o(msel[1]),
    .mem_data_o(mdata_o[1]), .mem_data_i(mdata_i[1])
  );

  assign mdata_i[0] = ram[0][maddr[0][5:2]];
  assign mdata_i[1] = ram[1][maddr[1][5:2]];

  // RAM model: commits enabled lanes on the edge where ce & we are high
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_clr) begin
        for (int i = 0; i < 16; i++) ram[d][i] <= 32'h0;
      end else if (ce[d] && mwe[d]) begin
        for (int l = 0; l < 4; l++)
          if (msel[d][l]) ram[d][maddr[d][5:2]][8*l +: 8] <= mdata_o[d][8*l +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outs(input int d, input string tag);
    chk({tag, " ctl"}, {26'h0, req_ready[d], resp_valid[d], resp_err[d], stall[d], ce[d], mwe[d]},
        32'h20);
    chk({tag, " rdata"}, resp_rdata[d], 32'h0);
    chk({tag, " mem"}, maddr[d] | mdata_o[d] | {28'h0, msel[d]}, 32'h0);
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after RESP
  task automatic do_req(input int d, input string tag, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input logic [3:0] exp_sel, input logic [31:0] exp_md);
    int n, ce_n, we_n;
    logic bad_r, bad_s;
    logic [3:0] got_sel;
    logic [31:0] got_md;
    req_we[d] = w; req_size[d] = sz; req_signed[d] = sg;
    req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = 1'b1;
    #1;
    chk({tag, " ready/stall@0"}, {30'h0, req_ready[d], stall[d]}, 32'h3);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    #1;
    n = 1; ce_n = 0; we_n = 0; bad_r = 1'b0; bad_s = 1'b0; got_sel = 4'h0; got_md = 32'h0;
    while (!resp_valid[d] && n < 20) begin
      if (ce[d]) ce_n++;
      if (mwe[d]) begin we_n++; got_sel = msel[d]; got_md = mdata_o[d]; end
      if (req_ready[d]) bad_r = 1'b1;
      if (stall[d] !== ce[d]) bad_s = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " rdata"}, resp_rdata[d], exp_rd);
    chk({tag, " err"}, {31'h0, resp_err[d]}, {31'h0, exp_err});
    chk({tag, " ready/stall busy"}, {30'h0, bad_r | req_ready[d], bad_s | stall[d]}, 32'h0);
    chk({tag, " ce cycles"}, 32'(ce_n), exp_err ? 32'h0 : 32'(exp_lat - 1));
    chk({tag, " we cycles"}, 32'(we_n), (w && !exp_err) ? 32'h1 : 32'h0);
    if (w && !exp_err) begin
      chk({tag, " sel"}, {28'h0, got_sel}, {28'h0, exp_sel});
      chk({tag, " wdata"}, got_md, exp_md);
    end
    @(posedge clk); #1;
    chk({tag, " after resp"}, {30'h0, resp_valid[d], req_ready[d]}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 2'b00; ram_clr = 1'b1;
    req_valid = '0; req_we = '0; req_signed = '0;
    req_size = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 ram_clr = 1'b0;
    chk_idle_outs(0, "reset0");
    chk_idle_outs(1, "reset3");
    @(negedge clk) rst = 2'b11;
    @(posedge clk); #1;

    // WAIT_CYCLES=0 instance
    do_req(0, "st_w",  1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 4'b1111, 32'hDEADBEEF);
    chk("ram after st_w", ram[0][4], 32'hDEADBEEF);
    do_req(0, "ld_w",  1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 4'h0, 32'h0);
    do_req(0, "ld_sb13", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 4'h0, 32'h0);
    do_req(0, "ld_ub12", 1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, 32'h000000BE, 1'b0, 2, 4'h0, 32'h0);
    do_req(0, "ld_sh10", 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 4'h0, 32'h0);
    do_req(0, "ld_uh12", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'h0000BEEF, 1'b0, 2, 4'h0, 32'h0);
    do_req(0, "st_b11", 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hFFFFFF5A, 32'h0, 1'b0, 2, 4'b0100, 32'h5A5A5A5A);
    do_req(0, "ld_w2", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDE5ABEEF, 1'b0, 2, 4'h0, 32'h0);
    do_req(0, "ld_sb11", 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'h0000005A, 1'b0, 2, 4'h0, 32'h0);
    do_req(0, "ld_sb10", 1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 4'h0, 32'h0);
    do_req(0, "st_h12", 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h1234A5C3, 32'h0, 1'b0, 2, 4'b0011, 32'hA5C3A5C3);
    chk("ram after st_h12", ram[0][4], 32'hDE5AA5C3);
    do_req(0, "err_h11", 1'b0, SZ_HALF, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1, 1, 4'h0, 32'h0);
    do_req(0, "err_w12", 1'b1, SZ_WORD, 1'b0, 32'h12, 32'h12345678, 32'h0, 1'b1, 1, 4'h0, 32'h0);
    do_req(0, "err_sz3", 1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 4'h0, 32'h0);
    chk("ram after errors", ram[0][4], 32'hDE5AA5C3);
    do_req(0, "ld_w3", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDE5AA5C3, 1'b0, 2, 4'h0, 32'h0);

    // WAIT_CYCLES=3 instance
    do_req(1, "w3_st", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 5, 4'b1111, 32'hCAFEF00D);
    do_req(1, "w3_ld", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 5, 4'h0, 32'h0);

    // Reset during the first ACCESS cycle of a store, before its write edge
    req_we[1] = 1'b1; req_size[1] = SZ_WORD; req_signed[1] = 1'b0;
    req_addr[1] = 32'h20; req_wdata[1] = 32'h11111111; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("rst_mid ce before", {31'h0, ce[1]}, 32'h1);
    rst[1] = 1'b0;
    #1;
    chk_idle_outs(1, "rst_mid");
    @(negedge clk);
    @(negedge clk) rst[1] = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid ram", ram[1][8], 32'hCAFEF00D);
    do_req(1, "w3_ld_post", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 5, 4'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that sits between the MEM pipeline stage and the word-organised, byte-laned data RAM.
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the RAM's ce/we/addr/sel/data, performs byte-lane alignment (big-endian) and load sign/zero extension, and reports misalignment.
- Stalls the pipeline for the duration of an access.

Parameters:
- ADDR_W, 32, byte address width.
- WAIT_CYCLES, 0, extra cycles the memory access is held before a load is sampled or a store is committed (0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when valid & ready.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed_i  in  1  load sign-extends when 1.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data, right-justified.
- resp_valid_o  out  1  one-cycle response pulse.
- resp_rdata_o  out  32  extended load data; 0 for stores and errors.
- resp_err_o  out  1  misaligned or illegal size; valid with resp_valid_o.
- stall_o  out  1  pipeline hold request.
- mem_ce_o  out  1  RAM chip enable.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  ADDR_W  RAM address, low 2 bits forced 0.
- mem_sel_o  out  4  byte enables; bit 3 = data[31:24].
- mem_data_o  out  32  lane-aligned store data.
- mem_data_i  in  32  RAM read data, combinational from mem_addr_o.

Behaviour:
- Reset values (rst=0): state IDLE, wait counter 0; all request registers 0. Outputs: req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, stall_o=0, mem_ce_o=0, mem_we_o=0, mem_addr_o=0, mem_sel_o=0, mem_data_o=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready_o=1. On valid, capture we/size/signed/addr/wdata.
  - Error check: size=11, half with addr[0]=1, or word with addr[1:0]≠00. Error goes to RESP with err flag set; otherwise go to ACCESS with counter=WAIT_CYCLES.
  - No memory signal asserted in IDLE.
- ACCESS:
  - mem_ce_o=1; mem_addr_o={addr[ADDR_W-1:2],2'b00}.
  - mem_sel_o and mem_data_o per lane rules below, held constant.
  - Counter decrements each cycle. When counter=0: mem_we_o=store (single cycle only; RAM commits at that edge), a load samples mem_data_i at that edge, and the FSM goes to RESP.
- RESP:
  - resp_valid_o=1 for exactly one cycle, then return to IDLE. req_ready_o=0.
  - mem_ce_o=0, mem_we_o=0.
- Latency: accept edge at cycle 0 → resp_valid_o in cycle 2+WAIT_CYCLES. Error responses arrive in cycle 1 with no memory activity.
- Lane rules (big-endian):
  - Byte: offset 0..3 → sel 1000/0100/0010/0001; wdata[7:0] replicated to all four lanes.
  - Half: offset 0 → 1100, offset 2 → 0011; wdata[15:0] replicated to both halves.
  - Word: 1111.
- Load extract: select lane by offset; sign-extend if signed, else zero-extend. Word loads pass through.
- stall_o = (state==ACCESS) | (state==IDLE & req_valid_i). It is 0 in RESP, so the pipeline advances on the response.
- A request offered while not IDLE is ignored (ready=0); the requester holds it.
- Reset mid-ACCESS: immediate return to IDLE. A store is not committed unless the write edge already occurred.
- Back-to-back: a new request is accepted in the IDLE cycle right after RESP. There is no RESP→ACCESS shortcut.

Decomposition:
- Shared package lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL), FSM state encoding, lane select constants.
- Sub-module lsu_lane_align: combinational. Takes size/offset/wdata/rdata/signed; produces sel, aligned store data, extended load data, misalign flag.
- FSM and counter remain in lsu_mem_ctrl.

Test Plan:
- Store word 0xDEADBEEF @0x10, then load word @0x10 (WAIT_CYCLES=0) → store: sel=1111, we pulse 1 cycle in cycle 1; load resp in cycle 2 with rdata=0xDEADBEEF, err=0.
- After that word: signed byte load @0x13 → 0xFFFFFFEF; unsigned byte load @0x12 → 0x000000BE; signed half load @0x10 → 0xFFFFDEAD.
- Store byte 0x5A @0x11 over 0xDEADBEEF → sel=0100, data=0x5A5A5A5A; word read back → 0xDE5ABEEF.
- Half load @0x11, word store @0x12, size=11 → resp in cycle 1 with err=1, rdata=0; mem_ce_o never asserted; memory contents unchanged.
- WAIT_CYCLES=3 load → ce high for 4 cycles, stall_o high through ACCESS, resp in cycle 5; req_ready_o=0 throughout.
- Drive rst=0 during the ACCESS of a store before its write edge → all outputs return to reset values at once; the target word is unchanged; the next load after reset is accepted normally.
